// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH valid/ready register stages with bubble collapsing,
// per-stage flush that refills killed slots with NOP_VAL, and occupancy/kill counters.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic [DEPTH-1:0] flush_mask,
  output logic [3:0]       occ,
  output logic [7:0]       kill_cnt
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] ev;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [WIDTH-1:0] dat_nxt [DEPTH];
  logic [WIDTH-1:0] src_dat [DEPTH];

  function automatic logic [3:0] count_ones(input logic [DEPTH-1:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {3'b000, b[i]};
    return c;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {5'b00000, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // The last stage is never masked out of ev: a flush there cannot pre-empt a
  // consumer handshake, it only kills the item when out_ready is low.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == DEPTH - 1) begin : g_last
      assign ev[g]   = vld[g];
      assign kill[g] = vld[g] & flush & flush_mask[g] & ~out_ready;
    end else begin : g_mid
      assign ev[g]   = vld[g] & ~(flush & flush_mask[g]);
      assign kill[g] = vld[g] & flush & flush_mask[g];
    end
    if (g == 0) begin : g_src_in
      assign src_vld[g] = in_valid;
      assign src_dat[g] = in_data;
    end else begin : g_src_up
      assign src_vld[g] = ev[g-1];
      assign src_dat[g] = dat[g-1];
    end
  end

  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = ~ev[i] | r;
      rdy[i] = r;
    end
  end

  always_comb begin
    vld_nxt = vld;
    for (int i = 0; i < DEPTH; i++) begin
      dat_nxt[i] = dat[i];
      if (rdy[i]) begin
        vld_nxt[i] = src_vld[i];
        dat_nxt[i] = src_vld[i] ? src_dat[i] : NOP_VAL;
      end else if (kill[i]) begin
        vld_nxt[i] = 1'b0;
        dat_nxt[i] = NOP_VAL;
      end
    end
  end

  // Stage registers and statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld      <= '0;
      occ      <= '0;
      kill_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= NOP_VAL;
    end else begin
      vld      <= vld_nxt;
      occ      <= count_ones(vld_nxt);
      kill_cnt <= sat_add(kill_cnt, count_ones(kill));
      for (int i = 0; i < DEPTH; i++) dat[i] <= dat_nxt[i];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule
